// File: rtl/ascon_cipher_collector.sv
// ascon_cipher_collector: gathers the 64-bit ciphertext words and the 128-bit
// tag of one ASCON encryption into a wide ciphertext register and a tag
// register. It flags protocol errors and holds the result until the next start.
module ascon_cipher_collector #(
  parameter int NB_BLOCKS = 23,
  parameter int LAST_BITS = 40,
  parameter int OUT_W     = 1448
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic [63:0]        cipher_i,
  input  logic               cipher_valid_i,
  input  logic [127:0]       tag_i,
  input  logic               end_tag_i,
  output logic [OUT_W-1:0]   cipher_o,
  output logic [127:0]       tag_o,
  output logic [4:0]         block_count_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_WAIT_TAG = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(NB_BLOCKS - 1);

  state_e             state_q, state_d;
  logic               valid_q;
  logic [OUT_W-1:0]   cipher_q, cipher_d;
  logic [127:0]       tag_q, tag_d;
  logic [4:0]         count_q, count_d;
  logic               error_q, error_d;
  logic               busy_q, done_q;

  logic               capture_s;
  logic               last_word_s;
  logic [OUT_W-1:0]   stored_s;

  // A word is taken only on the rising edge of the valid level.
  assign capture_s = cipher_valid_i & ~valid_q;

  // Ciphertext image with the incoming word written at the current count slot;
  // the final word keeps only its MSB-aligned valid bits.
  always_comb begin
    stored_s = cipher_q;
    for (int k = 0; k < NB_BLOCKS - 1; k++) begin
      stored_s[OUT_W-1-64*k -: 64] = (count_q == 5'(k)) ? cipher_i
                                                         : cipher_q[OUT_W-1-64*k -: 64];
    end
    stored_s[LAST_BITS-1:0] = (count_q == LAST_IDX) ? cipher_i[63 -: LAST_BITS]
                                                     : cipher_q[LAST_BITS-1:0];
  end

  // Next-state and datapath decisions; start has priority in every state.
  always_comb begin
    state_d     = state_q;
    cipher_d    = cipher_q;
    tag_d       = tag_q;
    count_d     = count_q;
    error_d     = error_q;
    last_word_s = capture_s && (count_q == LAST_IDX);
    if (start_i) begin
      cipher_d = {OUT_W{1'b0}};
      tag_d    = 128'h0;
      count_d  = 5'd0;
      error_d  = 1'b0;
      state_d  = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_COLLECT: begin
          if (capture_s) begin
            cipher_d = stored_s;
            count_d  = count_q + 5'd1;
          end else begin
            count_d  = count_q;
          end
          if (end_tag_i) begin
            // A tag before the last word has been seen is a short message.
            tag_d   = tag_i;
            error_d = error_q | ~last_word_s;
            state_d = S_DONE;
          end else if (last_word_s) begin
            state_d = S_WAIT_TAG;
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_WAIT_TAG: begin
          // Extra words are dropped; the count is already saturated.
          if (capture_s) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          if (end_tag_i) begin
            tag_d   = tag_i;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_TAG;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      cipher_q <= {OUT_W{1'b0}};
      tag_q    <= 128'h0;
      count_q  <= 5'd0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= cipher_valid_i;
      cipher_q <= cipher_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      error_q  <= error_d;
      busy_q   <= (state_d == S_COLLECT) || (state_d == S_WAIT_TAG);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign cipher_o      = cipher_q;
  assign tag_o         = tag_q;
  assign block_count_o = count_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule
